serial_add_ctrl: RTL and testbench

// - Bit-serial adder controller: adds two WIDTH-bit operands over WIDTH cycles.
// - Time-shares one 1-bit full-adder slice, built from two half adders, across all bit positions.
// - Provides a start/busy/done handshake so a host FSM can issue additions without a WIDTH-bit carry chain.
//

---
 rtl/serial_add_pkg.sv | 24 ++
 rtl/serial_add_ctrl_if.sv | 48 ++++
 rtl/serial_fa_slice.sv | 38 +++
 rtl/serial_half_adder.sv | 20 ++
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 6 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types, defaults and helpers for the bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Host-side start/busy/done and operand/result bundle.
//               sub_in exists only when SERIAL_ADD_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_in;
`endif
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output start_in, a_in, b_in, sub_in,
    input  busy_out, done_out, sum_out, carry_out
  );
  modport slave (
    input  start_in, a_in, b_in, sub_in,
    output busy_out, done_out, sum_out, carry_out
  );
`else
  modport master (
    output start_in, a_in, b_in,
    input  busy_out, done_out, sum_out, carry_out
  );
  modport slave (
    input  start_in, a_in, b_in,
    output busy_out, done_out, sum_out, carry_out
  );
`endif

endinterface

`default_nettype wire

// File: rtl/serial_fa_slice.sv
// ============================================================================
// Module      : serial_fa_slice
// Description : Combinational 1-bit full adder from two half adders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_slice (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_c,
  output logic      o_s,
  output logic      o_c
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  serial_half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  serial_half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (i_c),
    .o_s (o_s),
    .o_c (w_c1)
  );

  assign o_c = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/serial_half_adder.sv
// ============================================================================
// Module      : serial_half_adder
// Description : 1-bit half adder, building block of the serial slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_half_adder (
  input  wire logic i_a,
  input  wire logic i_b,
  output logic      o_s,
  output logic      o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller, one result bit per cycle, LSB
//               first. Optional subtract mode via SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic         clk_in,
  input wire logic         reset_in,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("serial_add_ctrl: WIDTH must be >= 2");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start_acc;
  logic             w_last;
  logic             w_sub_start;
  logic             w_b_bit;
  logic             w_s;
  logic             w_c;

  assign w_start_acc = (r_state == IDLE) && bus.start_in;
  assign w_last      = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  logic r_sub;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sub <= 1'b0;
    end else if (w_start_acc) begin
      r_sub <= bus.sub_in;
    end
  end

  assign w_sub_start = bus.sub_in;
  // Two's-complement subtract: invert B here, carry-in preset to 1 at start.
  assign w_b_bit     = r_b[0] ^ r_sub;
`else
  assign w_sub_start = 1'b0;
  assign w_b_bit     = r_b[0];
`endif

  serial_fa_slice u_slice (
    .i_a (r_a[0]),
    .i_b (w_b_bit),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start_in) w_next_state = RUN;
      RUN:     if (w_last)       w_next_state = DONE;
      DONE:                      w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_start_acc) begin
      r_a     <= bus.a_in;
      r_b     <= bus.b_in;
      r_carry <= w_sub_start;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      // The last slice bit is not in r_res yet, so assemble the result here.
      if (w_last) begin
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_c;
      end
    end
  end

  assign bus.busy_out  = (r_state != IDLE);
  assign bus.done_out  = (r_state == DONE);
  assign bus.sum_out   = r_sum;
  assign bus.carry_out = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Randomized and directed self-checking bench for serial_add_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk_in;
  logic reset_in;
  int   n_checks;
  int   n_fail;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {carry, sum} straight from arithmetic; subtract is A + ~B + 1.
  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic s);
    logic [WIDTH:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 1;
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic drive(input logic st, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic s);
    bus.start_in = st;
    bus.a_in     = a;
    bus.b_in     = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub_in   = s;
`else
    if (s) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
  endtask

  // One operation from IDLE; optional stray start pulse at RUN cycle inj.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic s, input int inj);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] held;
    logic             held_c;
    logic             moved;
    int               n;
    exp = ref_op(a, b, s);
    @(negedge clk_in);
    drive(1'b1, a, b, s);
    @(negedge clk_in);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check_eq({tag, ".busy_run"}, bus.busy_out, 1);
    held   = bus.sum_out;
    held_c = bus.carry_out;
    moved  = 1'b0;
    n      = 0;
    while (!bus.done_out && n < 40) begin
      if (n == inj)     drive(1'b1, 8'hAA, 8'h55, 1'b0);
      if (n == inj + 1) drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk_in);
      n++;
      if (!bus.done_out && (bus.sum_out !== held || bus.carry_out !== held_c)) moved = 1'b1;
    end
    check_eq({tag, ".latency"}, n, WIDTH);
    check_eq({tag, ".early_change"}, moved, 0);
    check_eq({tag, ".sum"}, bus.sum_out, exp[WIDTH-1:0]);
    check_eq({tag, ".carry"}, bus.carry_out, exp[WIDTH]);
    check_eq({tag, ".busy_done"}, bus.busy_out, 1);
    @(negedge clk_in);
    check_eq({tag, ".done_1cyc"}, bus.done_out, 0);
    check_eq({tag, ".idle"}, bus.busy_out, 0);
    check_eq({tag, ".hold"}, bus.sum_out, exp[WIDTH-1:0]);
  endtask

  initial begin
    logic [WIDTH:0]   e1;
    logic [WIDTH:0]   e2;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rs;
    int               t;
    int               t1;
    int               t2;
    int               dones;

    n_checks = 0;
    n_fail   = 0;
    reset_in = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk_in);
    check_eq("rst.busy", bus.busy_out, 0);
    check_eq("rst.done", bus.done_out, 0);
    check_eq("rst.sum", bus.sum_out, 0);
    check_eq("rst.carry", bus.carry_out, 0);
    reset_in = 1'b0;

    do_op("add0F01", 8'h0F, 8'h01, 1'b0, -5);
    do_op("ovfFF01", 8'hFF, 8'h01, 1'b0, -5);
    do_op("ovf8080", 8'h80, 8'h80, 1'b0, -5);
    do_op("busy0304", 8'h03, 8'h04, 1'b0, 3);
    repeat (WIDTH + 2) @(negedge clk_in);
    check_eq("busy.no_retrigger", bus.busy_out, 0);

    // Asynchronous reset in the middle of RUN cycle 4.
    do_op("pre_rst", 8'h5A, 8'h21, 1'b0, -5);
    @(negedge clk_in);
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    @(negedge clk_in);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk_in);
    #2 reset_in = 1'b1;
    #1;
    check_eq("arst.busy", bus.busy_out, 0);
    check_eq("arst.sum", bus.sum_out, 0);
    check_eq("arst.carry", bus.carry_out, 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    dones = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk_in);
      if (bus.done_out) dones++;
    end
    check_eq("arst.no_done", dones, 0);
    do_op("post_rst", 8'h33, 8'h44, 1'b0, -5);

    // Start held high: two back-to-back operations.
    e1 = ref_op(8'h12, 8'h34, 1'b0);
    e2 = ref_op(8'h01, 8'h01, 1'b0);
    @(negedge clk_in);
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 60) begin
      @(negedge clk_in);
      t++;
      if (bus.done_out) begin
        if (t1 < 0) begin
          t1 = t;
          check_eq("b2b.sum1", bus.sum_out, e1[WIDTH-1:0]);
          check_eq("b2b.carry1", bus.carry_out, e1[WIDTH]);
          drive(1'b1, 8'h01, 8'h01, 1'b0);
        end else begin
          t2 = t;
          check_eq("b2b.sum2", bus.sum_out, e2[WIDTH-1:0]);
          check_eq("b2b.carry2", bus.carry_out, e2[WIDTH]);
          drive(1'b0, 8'h00, 8'h00, 1'b0);
        end
      end
    end
    check_eq("b2b.spacing", t2 - t1, WIDTH + 2);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (WIDTH + 3) @(negedge clk_in);
    check_eq("b2b.idle", bus.busy_out, 0);

`ifdef SERIAL_ADD_SUB_EN
    do_op("sub0507", 8'h05, 8'h07, 1'b1, -5);
    do_op("sub0705", 8'h07, 8'h05, 1'b1, -5);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op($sformatf("rnd%0d", i), ra, rb, rs, -5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
